// File: rtl/servo_defs.sv
// Shared widths, FSM encodings and sign/magnitude helpers for the servo angle path.
// Used by servo_slew_limiter and its tick generator.
package servo_defs;

    localparam int unsigned MAG_W       = 8;
    localparam int unsigned POS_W       = 10;
    localparam int unsigned ANGLE_BUS_W = 16;
    localparam int unsigned STEP_W      = 4;

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StRamp = 1'b1;

    typedef logic [POS_W-1:0] pos_t;
    typedef logic [MAG_W-1:0] mag_t;

    // Magnitude of a two's-complement position; positions stay within +/-255.
    function automatic mag_t pos_mag(input pos_t p);
        pos_t n;
        n = p[POS_W-1] ? -p : p;
        return MAG_W'(n);
    endfunction

    function automatic pos_t signed_target(input mag_t m, input logic neg);
        pos_t p;
        p = {{(POS_W-MAG_W){1'b0}}, m};
        return neg ? -p : p;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: one-cycle tick every DIV clocks. Shared by the servo
// slew limiter and PWM update timing.
module tick_gen #(
    parameter int unsigned DIV = 50_000
) (
    input  logic clk,
    input  logic rst_a_n,
    output logic tick
);

    localparam int unsigned   CntW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == CntMax);
        cnt_d = tick ? '0 : cnt_q + CntW'(1);
    end

    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/servo_slew_limiter.sv
// Walks a registered servo position toward the commanded angle by a bounded step per tick.
// Define SLEW_ACCEL_EN to ramp the step size up from 1 instead of using MAX_STEP directly.
module servo_slew_limiter
    import servo_defs::*;
#(
    parameter int unsigned CLOCK_FREQ_HZ = 50_000_000,
    parameter int unsigned TICK_HZ       = 1000,
    parameter int unsigned MAX_STEP      = 4
) (
    input  logic                   clk,
    input  logic                   rst_a_n,
    input  logic                   enable,
    input  logic [ANGLE_BUS_W-1:0] target_abs,
    input  logic                   target_is_negative,
    output logic [ANGLE_BUS_W-1:0] servo_abs,
    output logic                   servo_is_negative,
    output logic                   busy,
    output logic                   arrived
);

    localparam int unsigned       TICK_DIV = CLOCK_FREQ_HZ / TICK_HZ;
    localparam logic [STEP_W-1:0] MaxStep  = STEP_W'(MAX_STEP);

    logic tick;

    tick_gen #(
        .DIV(TICK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .rst_a_n (rst_a_n),
        .tick    (tick)
    );

    pos_t              tgt_q, tgt_d;
    pos_t              pos_q, pos_d;
    pos_t              stepped;
    logic [0:0]        state_q, state_d;
    logic              arrived_q, arrived_d;
    logic [POS_W:0]    diff, diff_mag;
    logic              diff_neg;
    logic              at_target;
    logic              move, land;
    logic [STEP_W-1:0] eff_step, step;
    logic              unused_target_hi;

    assign unused_target_hi = ^target_abs[ANGLE_BUS_W-1:MAG_W];
    assign tgt_d = signed_target(target_abs[MAG_W-1:0], target_is_negative);

    // One candidate step toward tgt, clipped so it never overshoots.
    always_comb begin
        diff      = {tgt_q[POS_W-1], tgt_q} - {pos_q[POS_W-1], pos_q};
        diff_neg  = diff[POS_W];
        diff_mag  = diff_neg ? -diff : diff;
        at_target = (tgt_q == pos_q);
        step      = (diff_mag < {{(POS_W+1-STEP_W){1'b0}}, eff_step})
                    ? diff_mag[STEP_W-1:0] : eff_step;
        stepped   = diff_neg ? pos_q - {{(POS_W-STEP_W){1'b0}}, step}
                             : pos_q + {{(POS_W-STEP_W){1'b0}}, step};
        move      = enable && (state_q == StRamp) && !at_target && tick;
        land      = move && (stepped == tgt_q);
    end

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        arrived_d = 1'b0;
        if (!enable) begin
            state_d = StIdle;
            pos_d   = tgt_q;
        end else begin
            case (state_q)
                StIdle: begin
                    if (!at_target) begin
                        state_d = StRamp;
                    end
                end
                StRamp: begin
                    // A target that lands on pos between ticks ends the ramp silently.
                    if (at_target) begin
                        state_d = StIdle;
                    end else if (move) begin
                        pos_d = stepped;
                        if (land) begin
                            state_d   = StIdle;
                            arrived_d = 1'b1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

`ifdef SLEW_ACCEL_EN
    logic [STEP_W-1:0] cur_step_q, cur_step_d;
    logic              dir_q, dir_d;
    logic              reversal;

    // Step grows by one per moving tick; a direction change starts over at 1.
    always_comb begin
        reversal   = (dir_q != diff_neg);
        eff_step   = reversal ? STEP_W'(1) : cur_step_q;
        cur_step_d = cur_step_q;
        dir_d      = dir_q;
        if (!enable || ((state_q == StRamp) && (state_d == StIdle))) begin
            cur_step_d = STEP_W'(1);
        end else if (move) begin
            dir_d      = diff_neg;
            cur_step_d = (eff_step >= MaxStep) ? MaxStep : eff_step + STEP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            cur_step_q <= STEP_W'(1);
            dir_q      <= 1'b0;
        end else begin
            cur_step_q <= cur_step_d;
            dir_q      <= dir_d;
        end
    end
`else
    assign eff_step = MaxStep;
`endif

    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            tgt_q     <= '0;
            pos_q     <= '0;
            state_q   <= StIdle;
            arrived_q <= 1'b0;
        end else begin
            tgt_q     <= tgt_d;
            pos_q     <= pos_d;
            state_q   <= state_d;
            arrived_q <= arrived_d;
        end
    end

    assign servo_abs         = {{(ANGLE_BUS_W-MAG_W){1'b0}}, pos_mag(pos_q)};
    assign servo_is_negative = pos_q[POS_W-1];
    assign busy              = (state_q == StRamp);
    assign arrived           = arrived_q;

endmodule

// File: doc/servo_slew_limiter.md
# servo_slew_limiter

Rate-limits the angle command for one servo channel. It sits between the acelerómetro/secuencia angle mux and `pwm_controller`, with one instance per servo. It takes the mux's target (magnitude plus sign) and walks a registered position toward it by a bounded step on each slew tick, so the arm never jumps. Its outputs use the same magnitude/sign format that `pwm_controller` and `hex_to_angle` consume.

## Interface
- `CLOCK_FREQ_HZ`, default 50_000_000: clock frequency.
- `TICK_HZ`, default 1000: slew tick rate; `TICK_DIV = CLOCK_FREQ_HZ/TICK_HZ` cycles per tick.
- `MAX_STEP`, default 4: largest position change per tick, in counts (1..15).
- `clk`  in  1: system clock (MAX10_CLK1_50).
- `rst_a_n`  in  1: reset, asynchronous, active-low.
- `enable`  in  1: 1 = slew limiting on; 0 = bypass (output follows target).
- `target_abs`  in  16: target magnitude; only bits [7:0] are used, bits [15:8] are ignored.
- `target_is_negative`  in  1: target sign.
- `servo_abs`  out  16: limited magnitude; bits [15:8] are always 0.
- `servo_is_negative`  out  1: limited sign.
- `busy`  out  1: high while ramping.
- `arrived`  out  1: one-cycle pulse when the position reaches the target.

## Operation
- **Target register.** Each cycle, `tgt` ← signed 10-bit value: `-target_abs[7:0]` if `target_is_negative`, else `+target_abs[7:0]`. A magnitude of 0 gives 0 regardless of sign.
- **Position register.** `pos` is signed 10-bit, range -255..+255.
- **Outputs.** `servo_abs = |pos|`; `servo_is_negative = (pos < 0)`. Zero is always presented as positive.
- **Tick generator.** Free-running counter 0..`TICK_DIV`-1. `tick` is high for one cycle when the counter equals `TICK_DIV`-1. It is not affected by `enable`.
- **FSM states:** IDLE, RAMP.
  - IDLE → RAMP when `enable` and `tgt != pos`.
  - In RAMP, on each `tick`: `diff = tgt - pos` (11-bit signed), `step = min(cur_step, |diff|)`, and `pos` moves toward `tgt` by `step`.
  - RAMP → IDLE on the tick where `pos` becomes equal to `tgt`; `arrived` pulses at that point.
  - In RAMP, `tgt` can change between ticks. The next tick uses the new `tgt`. There is no stop and no pause.
  - If `tgt` becomes equal to `pos` without a tick moving `pos`, go to IDLE without pulsing `arrived`.
- **Bypass.** When `enable` = 0: `pos` ← `tgt` every cycle, state forced to IDLE, `busy` = 0, `arrived` = 0.
- **Leaving bypass.** On `enable` 0→1, ramping starts from the current `pos`. There is no jump.
- **`busy`** = 1 exactly when the state is RAMP.
- **`cur_step`** = `MAX_STEP` (constant) unless `SLEW_ACCEL_EN` is defined.

## Timing
- **Reset values:** `pos` = 0, `tgt` = 0, tick counter = 0, `cur_step` = 1 (accel) or `MAX_STEP`, state IDLE, `servo_abs` = 0, `servo_is_negative` = 0, `busy` = 0, `arrived` = 0.
- **Target latency:** a change on the target inputs is visible in `tgt` after 1 cycle.
- **First move:** happens on the first `tick` after the FSM enters RAMP.
- **Bypass latency:** 2 cycles from input to output.
- **`arrived`:** high in the same cycle the final `pos` value first appears on the outputs, for exactly 1 cycle.
- **Reset mid-ramp:** outputs go to 0/positive immediately (asynchronous). After release, the block ramps from 0 toward `tgt`.

## Configuration
- **`SLEW_ACCEL_EN` defined:** `cur_step` starts at 1 and increments by 1 per moving tick, saturating at `MAX_STEP`. It resets to 1 when arriving (RAMP→IDLE), and when `sign(diff)` reverses relative to the previous moving tick.
- **`SLEW_ACCEL_EN` undefined:** the step is constant `MAX_STEP` and there is no acceleration logic.

## Structure
- **Shared include/package `servo_defs`:**
  - `MAG_W` = 8
  - `POS_W` = 10
  - `ANGLE_BUS_W` = 16
  - FSM state encodings (IDLE = 0, RAMP = 1)
- **Sub-module `tick_gen`** (parameter `DIV`; ports `clk`, `rst_a_n`, `tick`). It is reusable by `angle_pwm` and `pwm_controller` update timing.

## Test plan
Use `CLOCK_FREQ_HZ` = 1000, `TICK_HZ` = 100 (10 cycles per tick) and `MAX_STEP` = 4.

1. Reset, then `enable` = 1 and target +20 → `pos` goes 4, 8, 12, 16, 20 on 5 successive ticks; `busy` is high throughout; `arrived` pulses once with `servo_abs` = 20.
2. From +8, target -8 (`target_is_negative` = 1) → `pos` goes 4, 0, -4, -8; at 0, `servo_is_negative` = 0; at -8, `servo_abs` = 8 and `servo_is_negative` = 1.
3. Ramping toward +40, with target changed to +10 at `pos` = 16 → next ticks give 12, then 10; `arrived` pulses once and never at 40.
4. `enable` = 0, target 200 → outputs show 200 within 2 cycles with `busy` = 0. Then `enable` = 1 and target 0 → ramp down by 4 per tick.
5. Assert `rst_a_n` mid-ramp at `pos` = 12 → outputs go to 0 immediately. After release with target still 20, ramp 4, 8, … from 0.
6. With `SLEW_ACCEL_EN` defined, target +20 from 0 → `pos` goes 1, 3, 6, 10, 14, 18, 20. On a reversal mid-ramp, the step restarts at 1.
